// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and opcode bytes from uart_rx,
// presents them registered to a combinational ALU, and launches the ALU
// result through uart_tx. An inter-byte timeout drops partial frames.
module uart_alu_ctrl #(
    parameter int N_BITS  = 8,
    parameter int N_OP    = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [N_BITS-1:0] rx_data,
    input  logic [N_BITS-1:0] alu_result,
    output logic [N_BITS-1:0] alu_a,
    output logic [N_BITS-1:0] alu_b,
    output logic [N_OP-1:0]   alu_op,
    output logic              tx_start,
    output logic [N_BITS-1:0] tx_data,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic              rx_overrun,
    output logic              timeout
);

    // Counter only ever holds values up to TIMEOUT-2; the timeout fires on the
    // edge where it would reach TIMEOUT-1, so it never wraps.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [N_BITS-1:0] a_next, b_next, tx_data_next;
    logic [N_OP-1:0]   op_next;
    logic              tx_start_next, busy_next, overrun_next, timeout_next;

    // Next-state, datapath capture and next values of every registered output.
    always_comb begin
        state_next    = state;
        cnt_next      = '0;
        a_next        = alu_a;
        b_next        = alu_b;
        op_next       = alu_op;
        tx_data_next  = tx_data;
        tx_start_next = 1'b0;
        overrun_next  = 1'b0;
        timeout_next  = 1'b0;
        case (state)
            WAIT_A: begin
                if (rx_done_tick) begin
                    a_next     = rx_data;
                    state_next = WAIT_B;
                end else begin
                    state_next = WAIT_A;
                end
            end
            WAIT_B: begin
                // A byte arriving on the terminal cycle wins over the timeout.
                if (rx_done_tick) begin
                    b_next     = rx_data;
                    state_next = WAIT_OP;
                end else if (cnt == CNT_LAST) begin
                    state_next   = WAIT_A;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    op_next    = rx_data[N_OP-1:0];
                    state_next = EXEC;
                end else if (cnt == CNT_LAST) begin
                    state_next   = WAIT_A;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle here.
                tx_data_next  = alu_result;
                tx_start_next = 1'b1;
                overrun_next  = rx_done_tick;
                state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_next = rx_done_tick;
                if (tx_done_tick) begin
                    state_next = WAIT_A;
                end else begin
                    state_next = WAIT_TX;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
        busy_next = (state_next == EXEC) || (state_next == WAIT_TX);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_A;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            rx_overrun <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            alu_a      <= a_next;
            alu_b      <= b_next;
            alu_op     <= op_next;
            tx_data    <= tx_data_next;
            tx_start   <= tx_start_next;
            busy       <= busy_next;
            rx_overrun <= overrun_next;
            timeout    <= timeout_next;
        end
    end

endmodule
